// File: rtl/yutorina_gpr_scoreboard.sv
// yutorina_gpr_scoreboard
//   This block tracks pending GPR writes, stalls issue on RAW/WAW hazards, and
//   merges two writeback sources onto the single register-file write port.
//
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   issue_*            instruction presented by decode/issue (rd, rs1, rs2 and their used/valid flags)
//   issue_stall        combinational; issue must hold this cycle
//   wb0_* / wb1_*      writeback requests (wb0 = ALU, wb1 = load/mul); ready is the combinational grant
//   gpr_we_            registered register-file write enable, active-low
//   gpr_w_addr/data    registered write address and data
//   busy               registered pending-write bit per GPR (bit 0 is always 0)
//   wb_err             sticky: an accepted beat targeted a non-zero register with no pending write
module yutorina_gpr_scoreboard #(
    parameter int unsigned GPR_NUM = 32,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_req,
    input  logic               issue_rd_valid,
    input  logic [ADDR_W-1:0]  issue_rd,
    input  logic               issue_rs1_used,
    input  logic               issue_rs2_used,
    input  logic [ADDR_W-1:0]  issue_rs1,
    input  logic [ADDR_W-1:0]  issue_rs2,
    output logic               issue_stall,
    input  logic               wb0_valid,
    input  logic               wb1_valid,
    input  logic [ADDR_W-1:0]  wb0_addr,
    input  logic [ADDR_W-1:0]  wb1_addr,
    input  logic [DATA_W-1:0]  wb0_data,
    input  logic [DATA_W-1:0]  wb1_data,
    output logic               wb0_ready,
    output logic               wb1_ready,
    output logic               gpr_we_,
    output logic [ADDR_W-1:0]  gpr_w_addr,
    output logic [DATA_W-1:0]  gpr_w_data,
    output logic [GPR_NUM-1:0] busy,
    output logic               wb_err
);

    typedef enum logic {
        SRC_WB0 = 1'b0,
        SRC_WB1 = 1'b1
    } src_t;

    src_t               last_grant;
    logic [GPR_NUM-1:0] clr_vec;
    logic [GPR_NUM-1:0] set_vec;
    logic [GPR_NUM-1:0] live_vec;
    logic [GPR_NUM-1:0] busy_next;
    logic               rs1_hit;
    logic               rs2_hit;
    logic               rd_hit;
    logic               issue_fire;
    logic               grant0;
    logic               grant1;
    logic               wb_fire;
    logic [ADDR_W-1:0]  win_addr;
    logic [DATA_W-1:0]  win_data;
    logic               beat_unexpected;

    // One-hot decode of a register address; addresses beyond GPR_NUM decode to nothing.
    function automatic logic [GPR_NUM-1:0] reg_dec(input logic [ADDR_W-1:0] a);
        logic [GPR_NUM-1:0] v;
        v = '0;
        for (int unsigned r = 0; r < GPR_NUM; r++) begin
            if (a == ADDR_W'(r)) begin
                v[r] = 1'b1;
            end
        end
        return v;
    endfunction

    // Hazard detection: a register being written this cycle is forwarded by
    // the register file, so its busy bit no longer blocks issue.
    always_comb begin
        clr_vec     = (!gpr_we_) ? reg_dec(gpr_w_addr) : '0;
        live_vec    = busy & ~clr_vec;
        rs1_hit     = |(live_vec & reg_dec(issue_rs1));
        rs2_hit     = |(live_vec & reg_dec(issue_rs2));
        rd_hit      = |(live_vec & reg_dec(issue_rd));
        issue_stall = issue_req && ((issue_rs1_used && rs1_hit) ||
                                    (issue_rs2_used && rs2_hit) ||
                                    (issue_rd_valid && rd_hit));
        issue_fire  = issue_req && !issue_stall && issue_rd_valid;
        set_vec     = issue_fire ? reg_dec(issue_rd) : '0;
        // Set is applied after clear so a same-cycle set wins.
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
    end

    // Round-robin arbitration: on a tie the source not granted last time wins.
    always_comb begin
        grant0    = wb0_valid && (!wb1_valid || (last_grant == SRC_WB1));
        grant1    = wb1_valid && !grant0;
        wb0_ready = grant0;
        wb1_ready = grant1;
        wb_fire   = grant0 || grant1;
        win_addr  = grant0 ? wb0_addr : wb1_addr;
        win_data  = grant0 ? wb0_data : wb1_data;
        beat_unexpected = wb_fire && (win_addr != '0) &&
                          !(|(busy & reg_dec(win_addr)));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy       <= '0;
            last_grant <= SRC_WB1;
            gpr_we_    <= 1'b1;
            gpr_w_addr <= '0;
            gpr_w_data <= '0;
            wb_err     <= 1'b0;
        end else begin
            busy    <= busy_next;
            gpr_we_ <= !wb_fire;
            if (wb_fire) begin
                gpr_w_addr <= win_addr;
                gpr_w_data <= win_data;
                last_grant <= grant1 ? SRC_WB1 : SRC_WB0;
            end
            if (beat_unexpected) begin
                wb_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_yutorina_gpr_scoreboard.sv
// tb_yutorina_gpr_scoreboard
//   Self-checking bench for yutorina_gpr_scoreboard. Accepted writeback beats
//   are pushed to an expected-write queue and popped when the register-file
//   write port fires; hazard, busy and error state come from a small model.
module tb_yutorina_gpr_scoreboard;

    localparam int unsigned GPR_NUM = 32;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned DATA_W  = 32;

    logic               clk;
    logic               rst;
    logic               issue_req;
    logic               issue_rd_valid;
    logic [ADDR_W-1:0]  issue_rd;
    logic               issue_rs1_used;
    logic               issue_rs2_used;
    logic [ADDR_W-1:0]  issue_rs1;
    logic [ADDR_W-1:0]  issue_rs2;
    logic               issue_stall;
    logic               wb0_valid;
    logic               wb1_valid;
    logic [ADDR_W-1:0]  wb0_addr;
    logic [ADDR_W-1:0]  wb1_addr;
    logic [DATA_W-1:0]  wb0_data;
    logic [DATA_W-1:0]  wb1_data;
    logic               wb0_ready;
    logic               wb1_ready;
    logic               gpr_we_;
    logic [ADDR_W-1:0]  gpr_w_addr;
    logic [DATA_W-1:0]  gpr_w_data;
    logic [GPR_NUM-1:0] busy;
    logic               wb_err;

    yutorina_gpr_scoreboard #(
        .GPR_NUM (GPR_NUM),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .issue_req      (issue_req),
        .issue_rd_valid (issue_rd_valid),
        .issue_rd       (issue_rd),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_stall    (issue_stall),
        .wb0_valid      (wb0_valid),
        .wb1_valid      (wb1_valid),
        .wb0_addr       (wb0_addr),
        .wb1_addr       (wb1_addr),
        .wb0_data       (wb0_data),
        .wb1_data       (wb1_data),
        .wb0_ready      (wb0_ready),
        .wb1_ready      (wb1_ready),
        .gpr_we_        (gpr_we_),
        .gpr_w_addr     (gpr_w_addr),
        .gpr_w_data     (gpr_w_data),
        .busy           (busy),
        .wb_err         (wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t                exp_q[$];
    logic [GPR_NUM-1:0] busy_m;
    logic               last_m;      // 1 = wb1 granted last
    logic               pend_m;      // model: write port fires this cycle
    logic [ADDR_W-1:0]  pend_addr_m;
    logic               err_m;
    int                 n_checks;
    int                 n_errors;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        issue_req      = 1'b0;
        issue_rd_valid = 1'b0;
        issue_rd       = '0;
        issue_rs1_used = 1'b0;
        issue_rs2_used = 1'b0;
        issue_rs1      = '0;
        issue_rs2      = '0;
        wb0_valid      = 1'b0;
        wb1_valid      = 1'b0;
        wb0_addr       = '0;
        wb1_addr       = '0;
        wb0_data       = '0;
        wb1_data       = '0;
    endtask

    task automatic model_reset();
        busy_m      = '0;
        last_m      = 1'b1;
        pend_m      = 1'b0;
        pend_addr_m = '0;
        err_m       = 1'b0;
        exp_q.delete();
    endtask

    function automatic logic hit_m(input logic [ADDR_W-1:0] r);
        return busy_m[r] && !(pend_m && (pend_addr_m == r));
    endfunction

    // One clock cycle with the currently driven inputs; starts and ends just after a negedge.
    task automatic cycle();
        logic               g0;
        logic               g1;
        logic               stall_e;
        logic [GPR_NUM-1:0] nb;
        logic [ADDR_W-1:0]  a;
        logic [DATA_W-1:0]  d;
        wr_t                w;
        #2;
        g0 = wb0_valid && (!wb1_valid || last_m);
        g1 = wb1_valid && !g0;
        stall_e = issue_req && ((issue_rs1_used && hit_m(issue_rs1)) ||
                                (issue_rs2_used && hit_m(issue_rs2)) ||
                                (issue_rd_valid && hit_m(issue_rd)));
        check("wb0_ready", 64'(wb0_ready), 64'(g0));
        check("wb1_ready", 64'(wb1_ready), 64'(g1));
        check("issue_stall", 64'(issue_stall), 64'(stall_e));
        @(posedge clk);
        nb = busy_m;
        if (pend_m) nb[pend_addr_m] = 1'b0;
        if (issue_req && !stall_e && issue_rd_valid && (issue_rd != '0)) nb[issue_rd] = 1'b1;
        a = g0 ? wb0_addr : wb1_addr;
        d = g0 ? wb0_data : wb1_data;
        if (g0 || g1) begin
            if ((a != '0) && !busy_m[a]) err_m = 1'b1;
            exp_q.push_back('{addr: a, data: d});
            last_m = g1;
        end
        pend_m      = g0 || g1;
        pend_addr_m = a;
        busy_m      = nb;
        @(negedge clk);
        check("busy", 64'(busy), 64'(busy_m));
        check("wb_err", 64'(wb_err), 64'(err_m));
        check("gpr_we_", 64'(gpr_we_), 64'(!pend_m));
        if (!gpr_we_ && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            check("gpr_w_addr", 64'(gpr_w_addr), 64'(w.addr));
            check("gpr_w_data", 64'(gpr_w_data), 64'(w.data));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_gpr_we_"}, 64'(gpr_we_), 64'd1);
        check({tag, "_wb_err"}, 64'(wb_err), 64'd0);
        check({tag, "_gpr_w_addr"}, 64'(gpr_w_addr), 64'd0);
        check({tag, "_gpr_w_data"}, 64'(gpr_w_data), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        idle();
        model_reset();
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset_init");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        idle(); cycle();

        // RAW hazard on r5 resolved by a wb1 beat
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 5; cycle();
        idle(); issue_req = 1; issue_rs1_used = 1; issue_rs1 = 5; cycle();
        wb1_valid = 1; wb1_addr = 5; wb1_data = 32'hDEADBEEF; cycle();
        wb1_valid = 0; cycle();
        idle(); cycle();

        // Same-cycle set and clear on r7
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 7; cycle();
        idle(); wb0_valid = 1; wb0_addr = 7; wb0_data = 32'h0000_0077; cycle();
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 7; cycle();
        idle(); cycle();

        // Register zero never becomes busy and a beat to it is not an error
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 0; cycle();
        idle(); issue_req = 1; issue_rs1_used = 1; issue_rs1 = 0; cycle();
        idle(); wb0_valid = 1; wb0_addr = 0; wb0_data = 32'h0000_1234; cycle();
        idle(); cycle();

        // Contention between wb0 (r3) and wb1 (r4)
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 3; cycle();
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 4; issue_rs2_used = 1; issue_rs2 = 3; cycle();
        idle();
        wb0_valid = 1; wb0_addr = 3; wb0_data = 32'hA3A3_0003;
        wb1_valid = 1; wb1_addr = 4; wb1_data = 32'hB4B4_0004;
        repeat (4) cycle();
        idle(); cycle(); cycle();

        // Reset mid-run with busy[5] set and a beat to r6 in the output stage
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 5; cycle();
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 6; cycle();
        idle(); wb0_valid = 1; wb0_addr = 6; wb0_data = 32'h0000_0066; cycle();
        idle();
        rst = 1'b0;
        #1 check_reset_outputs("reset_mid");
        model_reset();
        @(negedge clk);
        check("reset_hold_gpr_we_", 64'(gpr_we_), 64'd1);
        rst = 1'b1;
        cycle();
        cycle();

        // Unexpected beat to r9 sets the sticky error
        idle(); wb0_valid = 1; wb0_addr = 9; wb0_data = 32'h0000_0099; cycle();
        idle(); repeat (3) cycle();
        idle(); issue_req = 1; issue_rd_valid = 1; issue_rd = 9; cycle();
        idle(); wb1_valid = 1; wb1_addr = 9; wb1_data = 32'h9999_0009; cycle();
        idle(); cycle(); cycle();

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
